// File: rtl/dm_ctrl.sv
// dm_ctrl: data-memory controller between the core DM port and a
// single-port synchronous SRAM. It takes one read or write per request,
// inserts WAIT_CYCLES wait states before the SRAM strobe, and bounds-checks
// the address. The core is held with dm_stall until the access is done.
module dm_ctrl #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DM_enable,
  input  logic              DM_read,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_address,
  input  logic [DATA_W-1:0] DM_in,
  output logic [DATA_W-1:0] DM_out,
  output logic              dm_stall,
  output logic              dm_error,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // The wait counter is only 4 bits wide, and the depth must fit the address.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("dm_ctrl: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH_WORDS < 1 || DEPTH_WORDS > (1 << ADDR_W)) begin : g_bad_depth
    $error("dm_ctrl: DEPTH_WORDS must be in 1..2**ADDR_W");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP,
    S_DONE
  } state_t;

  // Counter load value on entry to WAIT; WAIT exits when it reaches zero,
  // so exactly WAIT_CYCLES cycles are spent there.
  localparam logic [3:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  // One extra bit so DEPTH_WORDS == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              err_q, err_d;
  logic              cs_q, cs_d;
  logic              we_q, we_d;

  logic req_ok;
  logic in_range;

  assign req_ok   = DM_read ^ DM_write;
  assign in_range = {1'b0, DM_address} < DEPTH_L;

  // Stall is combinational so the core freezes in the very request cycle.
  assign dm_stall = ((state_q == S_IDLE) & DM_enable) |
                    (state_q == S_WAIT) | (state_q == S_ACCESS) |
                    (state_q == S_RESP);

  assign DM_out    = dout_q;
  assign dm_error  = err_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Next-state and registered-output decode; strobes are set on entry to
  // ACCESS so mem_cs/mem_we are high for exactly the ACCESS cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    err_d   = 1'b0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (DM_enable) begin
          if (!req_ok) begin
            // Both or neither of read/write: flag and skip the SRAM.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (!in_range) begin
            // Out-of-range read returns zero; write leaves DM_out alone.
            err_d   = 1'b1;
            if (DM_read) dout_d = '0;
            state_d = S_DONE;
          end else begin
            addr_d  = DM_address;
            wdata_d = DM_in;
            wr_d    = DM_write;
            if (WAIT_CYCLES == 0) begin
              cs_d    = 1'b1;
              we_d    = DM_write;
              state_d = S_ACCESS;
            end else begin
              cnt_d   = WAIT_INIT;
              state_d = S_WAIT;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          cs_d    = 1'b1;
          we_d    = wr_q;
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACCESS: begin
        state_d = wr_q ? S_DONE : S_RESP;
      end
      S_RESP: begin
        // SRAM data is valid the cycle after the strobe.
        dout_d  = mem_rdata;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
    end
  end

endmodule
